// File: rtl/adder_16bit.sv
// Registered adder with carry-in, carry-out and overflow/zero flags, used for PC sequencing.
// The sum is built from 4-bit carry-lookahead groups whose carries ripple group to group.
module adder_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NGROUP = WIDTH / 4;

    // One lookahead group: returns {carry_out, sum[3:0]}
    function automatic logic [4:0] cla4(input logic [3:0] ga, input logic [3:0] gb, input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = ga & gb;
        p    = ga ^ gb;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    logic [WIDTH-1:0] sum_s;
    logic [NGROUP:0]  carry_s;
    logic             overflow_s;
    logic             zero_s;

    logic [WIDTH-1:0] result_d, result_q;
    logic             cout_d, cout_q;
    logic             overflow_d, overflow_q;
    logic             zero_d, zero_q;

    // Carry-lookahead sum and status flags for the current operands
    always_comb begin
        logic [4:0] grp;
        sum_s      = {WIDTH{1'b0}};
        carry_s    = {(NGROUP+1){1'b0}};
        carry_s[0] = cin;
        for (int i = 0; i < NGROUP; i++) begin
            grp            = cla4(a[i*4 +: 4], b[i*4 +: 4], carry_s[i]);
            sum_s[i*4 +: 4] = grp[3:0];
            carry_s[i+1]   = grp[4];
        end
        overflow_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
        zero_s     = (sum_s == {WIDTH{1'b0}});
    end

    // Next-state selection: capture the new sum when enabled, otherwise hold
    always_comb begin
        result_d   = result_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        if (en) begin
            result_d   = sum_s;
            cout_d     = carry_s[NGROUP];
            overflow_d = overflow_s;
            zero_d     = zero_s;
        end else begin
            result_d   = result_q;
            cout_d     = cout_q;
            overflow_d = overflow_q;
            zero_d     = zero_q;
        end
    end

    // Output registers; reset is asynchronous so outputs clear without a clock edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q   <= {WIDTH{1'b0}};
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            result_q   <= result_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_adder_16bit.sv
// Self-checking bench for adder_16bit: directed vector table, hold/reset sequences,
// and a random stream compared against an integer-arithmetic reference model.
module tb_adder_16bit;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] result;
    logic        cout;
    logic        overflow;
    logic        zero;

    int n_assert;
    int n_fail;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    vec_t vecs[6];
    exp_t q[$];

    adder_16bit #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned and signed integer sums, flags derived from their ranges
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mc);
        exp_t e;
        int   us;
        int   ss;
        us     = int'(ma) + int'(mb) + int'(mc);
        ss     = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
        e.res  = us[15:0];
        e.cout = (us > 65535);
        e.ovf  = (ss > 32767) || (ss < -32768);
        e.zero = ((us % 65536) == 0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic chk_out(input string nm, input exp_t e);
        chk({nm, ".result"},   result,           e.res);
        chk({nm, ".cout"},     {15'd0, cout},     {15'd0, e.cout});
        chk({nm, ".overflow"}, {15'd0, overflow}, {15'd0, e.ovf});
        chk({nm, ".zero"},     {15'd0, zero},     {15'd0, e.zero});
    endtask

    initial begin
        exp_t rst_e;
        exp_t e;
        exp_t hold_e;
        n_assert = 0;
        n_fail   = 0;
        rst_e    = '{res: 16'h0000, cout: 1'b0, ovf: 1'b0, zero: 1'b1};

        vecs[0] = '{"pc_inc",   16'h0010, 16'h0004, 1'b0, 16'h0014, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"uwrap",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{"ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"ovf_neg",  16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{"carry_in", 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"load",     16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; en = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        #2;
        chk_out("reset_init", rst_e);
        repeat (2) @(negedge clk);
        chk_out("reset_held", rst_e);
        en  = 1'b0;
        rst = 1'b0;

        // Directed table, one operation per cycle with a check one edge later
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; en = 1'b1;
            @(negedge clk);
            e = '{res: vecs[i].res, cout: vecs[i].cout, ovf: vecs[i].ovf, zero: vecs[i].zero};
            chk_out(vecs[i].name, e);
        end

        // Hold: en low, operands changing, outputs must not move
        hold_e = '{res: 16'h2345, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
        en = 1'b0; a = 16'hAAAA;
        for (int i = 0; i < 3; i++) begin
            b   = 16'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
            chk_out("hold", hold_e);
        end

        // Streaming: new operands every cycle, each sum one edge later
        en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (q.size() != 0) chk_out("stream", q.pop_front());
            if (i == 59) begin
                a = 16'h0001; b = 16'h0001; cin = 1'b0;
            end else begin
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            end
            q.push_back(model(a, b, cin));
            @(negedge clk);
        end
        chk_out("stream_last", q.pop_front());

        // Async reset between edges with nonzero outputs
        en = 1'b0;
        #2 rst = 1'b1;
        #1 chk_out("async_reset", rst_e);

        // Reset wins over enable on the same edge
        en = 1'b1; a = 16'h0005; b = 16'h0006; cin = 1'b0;
        @(negedge clk);
        chk_out("rst_precedence", rst_e);
        rst = 1'b0;
        a = 16'h0003; b = 16'h0004;
        @(negedge clk);
        chk_out("resume", model(16'h0003, 16'h0004, 1'b0));

        // Reset right after a capture discards it; nothing pending afterwards
        a = 16'h0009; b = 16'h0009;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_out("mid_op_reset", rst_e);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        @(negedge clk);
        chk_out("no_pending", rst_e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
